// File: rtl/sfr_bus_arb_pkg.sv
// sfr_arb_pkg: shared types and constants for the SFR bus arbiter slice.
//   - SFR_ADDR_W / SFR_DATA_W : default SFR address / data widths
//   - SFR_STARVE_MAX          : default engine wait limit for the starvation flag
//   - SFR_IDLE_ADDR           : address driven onto the memory when the bus is idle
//   - arb_state_e             : engine-side FSM states
//   - starve_cnt_w()          : width of a counter that must hold 0..max
package sfr_arb_pkg;

    localparam int unsigned SFR_ADDR_W     = 8;
    localparam int unsigned SFR_DATA_W     = 8;
    localparam int unsigned SFR_STARVE_MAX = 16;

    localparam logic [SFR_ADDR_W-1:0] SFR_IDLE_ADDR = 8'h00;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PEND = 2'd1,
        DONE = 2'd2
    } arb_state_e;

    function automatic int unsigned starve_cnt_w(input int unsigned max_val);
        return $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/sfr_bus_arb_if.sv
// sfr_bus_arb_if: bundles the core SFR bus, the I2C engine request port and
// the SFR memory port around the arbiter.
//   modport slave  : the arbiter's view (core/engine requests in, memory strobes out)
//   modport master : the environment's view (core, engine and memory)
interface sfr_bus_arb_if
    import sfr_arb_pkg::*;
#(
    parameter int unsigned ADDR_W = SFR_ADDR_W,
    parameter int unsigned DATA_W = SFR_DATA_W
);

    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic              cpu_wr_n;
    logic              cpu_rd_n;
    logic [DATA_W-1:0] cpu_rdata;

    logic              eng_req;
    logic              eng_we;
    logic [ADDR_W-1:0] eng_addr;
    logic [DATA_W-1:0] eng_wdata;
    logic              eng_gnt;
    logic              eng_done;
    logic [DATA_W-1:0] eng_rdata;
    logic              eng_starve;

    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_wr_n;
    logic              mem_rd_n;

    modport slave (
        input  cpu_addr, cpu_wdata, cpu_wr_n, cpu_rd_n,
        input  eng_req, eng_we, eng_addr, eng_wdata,
        input  mem_rdata,
        output cpu_rdata,
        output eng_gnt, eng_done, eng_rdata, eng_starve,
        output mem_addr, mem_wdata, mem_wr_n, mem_rd_n
    );

    modport master (
        output cpu_addr, cpu_wdata, cpu_wr_n, cpu_rd_n,
        output eng_req, eng_we, eng_addr, eng_wdata,
        output mem_rdata,
        input  cpu_rdata,
        input  eng_gnt, eng_done, eng_rdata, eng_starve,
        input  mem_addr, mem_wdata, mem_wr_n, mem_rd_n
    );

endinterface

// File: rtl/sfr_starve_cnt.sv
// sfr_starve_cnt: counts the cycles a latched engine access loses to the core
// and raises a sticky starvation flag once the count reaches STARVE_MAX.
// Built only when SFR_ARB_STARVE_EN is defined.
//   clk, rst_n : clock, synchronous active-low reset
//   pend       : engine access is waiting for the bus
//   busy       : core owns the bus this cycle
//   starve     : sticky flag, cleared only by reset
`ifdef SFR_ARB_STARVE_EN
module sfr_starve_cnt
    import sfr_arb_pkg::*;
#(
    parameter int unsigned STARVE_MAX = SFR_STARVE_MAX
) (
    input  logic clk,
    input  logic rst_n,
    input  logic pend,
    input  logic busy,
    output logic starve
);

    localparam int unsigned          CNT_W   = starve_cnt_w(STARVE_MAX);
    localparam logic [CNT_W-1:0]     CNT_MAX = CNT_W'(STARVE_MAX);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;

    // Saturating count of lost cycles; restarts for every new pending access.
    always_comb begin
        cnt_nxt = cnt;
        if (!pend) begin
            cnt_nxt = '0;
        end else if (busy && (cnt != CNT_MAX)) begin
            cnt_nxt = cnt + CNT_W'(1);
        end
    end

    // Flag is set from the next count so it rises on the same edge the limit is hit.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt    <= '0;
            starve <= 1'b0;
        end else begin
            cnt <= cnt_nxt;
            if (cnt_nxt == CNT_MAX) begin
                starve <= 1'b1;
            end
        end
    end

endmodule
`endif

// File: rtl/sfr_bus_arb.sv
// sfr_bus_arb: shares the single-port SFR memory between the 8051 core bus
// and the I2C engine. The core path is combinational and never stalled; an
// engine access is latched on grant and issued in the first core-idle cycle.
//   clk, rst_n : clock, synchronous active-low reset
//   bus        : sfr_bus_arb_if.slave (core bus, engine port, memory port)
// Optional feature: define SFR_ARB_STARVE_EN to build the engine starvation
// counter (parameter STARVE_MAX); otherwise eng_starve is tied low.
module sfr_bus_arb
    import sfr_arb_pkg::*;
#(
    parameter int unsigned ADDR_W = SFR_ADDR_W,
    parameter int unsigned DATA_W = SFR_DATA_W
`ifdef SFR_ARB_STARVE_EN
    ,
    parameter int unsigned STARVE_MAX = SFR_STARVE_MAX
`endif
) (
    input  logic         clk,
    input  logic         rst_n,
    sfr_bus_arb_if.slave bus
);

    arb_state_e        state;
    arb_state_e        state_nxt;
    logic              cpu_busy;
    logic              eng_accept;
    logic              eng_issue;
    logic              issue_en;

    logic              lat_we;
    logic [ADDR_W-1:0] lat_addr;
    logic [DATA_W-1:0] lat_wdata;
    logic [DATA_W-1:0] rdata_q;

    assign cpu_busy = !bus.cpu_wr_n || !bus.cpu_rd_n;

    // Reset blanks an issue cycle so a discarded access never reaches memory.
    assign issue_en = eng_issue && rst_n;

    // Next state; grant and issue are decided here.
    always_comb begin
        state_nxt  = state;
        eng_accept = 1'b0;
        eng_issue  = 1'b0;
        case (state)
            IDLE: begin
                if (bus.eng_req) begin
                    eng_accept = 1'b1;
                    state_nxt  = PEND;
                end
            end
            PEND: begin
                if (!cpu_busy) begin
                    eng_issue = 1'b1;
                    state_nxt = DONE;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // State register, request latch and engine read capture.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            lat_we    <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            rdata_q   <= '0;
        end else begin
            state <= state_nxt;
            if (eng_accept) begin
                lat_we    <= bus.eng_we;
                lat_addr  <= bus.eng_addr;
                lat_wdata <= bus.eng_wdata;
            end
            if (eng_issue && !lat_we) begin
                rdata_q <= bus.mem_rdata;
            end
        end
    end

    // Memory port mux: core first, then a pending engine access, else idle.
    always_comb begin
        bus.mem_addr  = ADDR_W'(SFR_IDLE_ADDR);
        bus.mem_wdata = '0;
        bus.mem_wr_n  = 1'b1;
        bus.mem_rd_n  = 1'b1;
        if (cpu_busy) begin
            bus.mem_addr  = bus.cpu_addr;
            bus.mem_wdata = bus.cpu_wdata;
            bus.mem_wr_n  = bus.cpu_wr_n;
            bus.mem_rd_n  = bus.cpu_rd_n;
        end else if (issue_en) begin
            bus.mem_addr  = lat_addr;
            bus.mem_wdata = lat_wdata;
            bus.mem_wr_n  = !lat_we;
            bus.mem_rd_n  = lat_we;
        end
    end

    assign bus.cpu_rdata = bus.mem_rdata;
    assign bus.eng_gnt   = eng_accept && rst_n;
    assign bus.eng_done  = (state == DONE);
    assign bus.eng_rdata = rdata_q;

`ifdef SFR_ARB_STARVE_EN
    sfr_starve_cnt #(
        .STARVE_MAX(STARVE_MAX)
    ) u_starve_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .pend  (state == PEND),
        .busy  (cpu_busy),
        .starve(bus.eng_starve)
    );
`else
    assign bus.eng_starve = 1'b0;
`endif

endmodule

// File: tb/tb_sfr_bus_arb.sv
// tb_sfr_bus_arb: self-checking bench for sfr_bus_arb. Models the SFR memory
// (combinational read, write on clock edge, preloaded with addr ^ 8'h5A) and
// keeps a queue of expected engine results popped on eng_done.
// Honours SFR_ARB_STARVE_EN (STARVE_MAX overridden to 4 when defined).
module tb_sfr_bus_arb;

    typedef struct packed {
        logic       we;
        logic [7:0] addr;
        logic [7:0] data;
    } exp_t;

`ifdef SFR_ARB_STARVE_EN
    localparam bit STARVE_ON = 1'b1;
`else
    localparam bit STARVE_ON = 1'b0;
`endif
    localparam int TB_STARVE_MAX = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  sfr_mem [256];
    logic        mem_loaded = 1'b0;
    int unsigned wr_count = 0;
    exp_t        sb_q[$];
    int          checks = 0;
    int          failures = 0;

    sfr_bus_arb_if bus ();

`ifdef SFR_ARB_STARVE_EN
    sfr_bus_arb #(.STARVE_MAX(TB_STARVE_MAX)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
`else
    sfr_bus_arb dut (.clk(clk), .rst_n(rst_n), .bus(bus));
`endif

    always #5 clk = ~clk;

    function automatic logic [7:0] init_val(input logic [7:0] a);
        return a ^ 8'h5A;
    endfunction

    assign bus.mem_rdata = sfr_mem[bus.mem_addr];

    always @(posedge clk) begin
        if (!mem_loaded) begin
            for (int i = 0; i < 256; i++) sfr_mem[i] <= init_val(8'(i));
            mem_loaded <= 1'b1;
        end else if (bus.mem_wr_n == 1'b0) begin
            sfr_mem[bus.mem_addr] <= bus.mem_wdata;
            wr_count <= wr_count + 1;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic cpu_drive(input logic wr_n, input logic rd_n, input logic [7:0] addr, input logic [7:0] wdata);
        bus.cpu_wr_n  = wr_n;
        bus.cpu_rd_n  = rd_n;
        bus.cpu_addr  = addr;
        bus.cpu_wdata = wdata;
    endtask

    task automatic eng_drive(input logic we, input logic [7:0] addr, input logic [7:0] wdata);
        bus.eng_req   = 1'b1;
        bus.eng_we    = we;
        bus.eng_addr  = addr;
        bus.eng_wdata = wdata;
    endtask

    // Waits (bounded) for eng_done; n counts sampled cycles without done.
    task automatic wait_done(input int budget, output int n, output bit ok);
        n  = 0;
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (bus.eng_done === 1'b1) begin
                ok = 1'b1;
                break;
            end
            n++;
        end
    endtask

    task automatic test_reset();
        cpu_drive(1'b1, 1'b1, 8'h00, 8'h00);
        rst_n = 1'b0;
        eng_drive(1'b1, 8'h50, 8'h77);
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++; if (bus.eng_gnt !== 1'b0) begin failures++; $display("FAIL rst_gnt: got %b want 0", bus.eng_gnt); end
        checks++; if (bus.eng_done !== 1'b0) begin failures++; $display("FAIL rst_done: got %b want 0", bus.eng_done); end
        checks++; if (bus.eng_rdata !== 8'h00) begin failures++; $display("FAIL rst_rdata: got %h want 00", bus.eng_rdata); end
        checks++; if (bus.eng_starve !== 1'b0) begin failures++; $display("FAIL rst_starve: got %b want 0", bus.eng_starve); end
        checks++; if (bus.mem_wr_n !== 1'b1 || bus.mem_rd_n !== 1'b1) begin failures++; $display("FAIL rst_strobes: got wr_n=%b rd_n=%b want 1/1", bus.mem_wr_n, bus.mem_rd_n); end
        checks++; if (bus.mem_addr !== 8'h00) begin failures++; $display("FAIL rst_idle_addr: got %h want 00", bus.mem_addr); end
        step();
        rst_n = 1'b1;
        @(negedge clk);
        checks++; if (bus.eng_gnt !== 1'b1) begin failures++; $display("FAIL rst_first_gnt: got %b want 1", bus.eng_gnt); end
        step();
        bus.eng_req = 1'b0;
        repeat (3) step();
    endtask

    task automatic test_eng_write();
        exp_t e;
        sb_q.push_back('{we: 1'b1, addr: 8'h90, data: 8'hA5});
        eng_drive(1'b1, 8'h90, 8'hA5);
        @(negedge clk);
        checks++; if (bus.eng_gnt !== 1'b1) begin failures++; $display("FAIL wr_gnt: got %b want 1", bus.eng_gnt); end
        step();
        bus.eng_req = 1'b0;
        @(negedge clk);
        checks++; if (bus.eng_gnt !== 1'b0) begin failures++; $display("FAIL wr_gnt_pulse: got %b want 0", bus.eng_gnt); end
        checks++; if (bus.mem_wr_n !== 1'b0 || bus.mem_rd_n !== 1'b1) begin failures++; $display("FAIL wr_issue_strobes: got wr_n=%b rd_n=%b want 0/1", bus.mem_wr_n, bus.mem_rd_n); end
        checks++; if (bus.mem_addr !== 8'h90 || bus.mem_wdata !== 8'hA5) begin failures++; $display("FAIL wr_issue_bus: got %h/%h want 90/a5", bus.mem_addr, bus.mem_wdata); end
        checks++; if (bus.eng_done !== 1'b0) begin failures++; $display("FAIL wr_early_done: got %b want 0", bus.eng_done); end
        step();
        @(negedge clk);
        checks++; if (bus.eng_done !== 1'b1) begin failures++; $display("FAIL wr_done: got %b want 1", bus.eng_done); end
        checks++;
        if (sb_q.size() == 0) begin failures++; $display("FAIL wr_sb: got empty queue want entry"); end
        else begin
            e = sb_q.pop_front();
            if (sfr_mem[e.addr] !== e.data) begin failures++; $display("FAIL wr_mem: got %h want %h", sfr_mem[e.addr], e.data); end
        end
        step();
        cpu_drive(1'b1, 1'b0, 8'h90, 8'h00);
        @(negedge clk);
        checks++; if (bus.cpu_rdata !== 8'hA5) begin failures++; $display("FAIL wr_cpu_readback: got %h want a5", bus.cpu_rdata); end
        checks++; if (bus.eng_done !== 1'b0) begin failures++; $display("FAIL wr_done_pulse: got %b want 0", bus.eng_done); end
        step();
        cpu_drive(1'b1, 1'b1, 8'h00, 8'h00);
    endtask

    task automatic test_core_priority();
        exp_t e;
        int   n;
        bit   ok;
        sb_q.push_back('{we: 1'b0, addr: 8'h91, data: 8'hCB});
        eng_drive(1'b0, 8'h91, 8'h00);
        @(negedge clk);
        checks++; if (bus.eng_gnt !== 1'b1) begin failures++; $display("FAIL pri_gnt: got %b want 1", bus.eng_gnt); end
        step();
        bus.eng_req = 1'b0;
        cpu_drive(1'b1, 1'b0, 8'h80, 8'h00);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++; if (bus.cpu_rdata !== 8'hDA || bus.mem_addr !== 8'h80) begin failures++; $display("FAIL pri_core_read%0d: got addr %h data %h want 80/da", i, bus.mem_addr, bus.cpu_rdata); end
            checks++; if (bus.eng_done !== 1'b0) begin failures++; $display("FAIL pri_done_early%0d: got %b want 0", i, bus.eng_done); end
            step();
        end
        cpu_drive(1'b1, 1'b1, 8'h00, 8'h00);
        wait_done(8, n, ok);
        checks++; if (!ok) begin failures++; $display("FAIL pri_timeout: got no eng_done want eng_done"); end
        checks++; if (4 + n != 5) begin failures++; $display("FAIL pri_latency: got %0d want 5", 4 + n); end
        checks++;
        if (sb_q.size() == 0) begin failures++; $display("FAIL pri_sb: got empty queue want entry"); end
        else begin
            e = sb_q.pop_front();
            if (bus.eng_rdata !== e.data) begin failures++; $display("FAIL pri_rdata: got %h want %h", bus.eng_rdata, e.data); end
        end
        step();
        @(negedge clk);
        checks++; if (bus.eng_rdata !== 8'hCB) begin failures++; $display("FAIL pri_rdata_hold: got %h want cb", bus.eng_rdata); end
        step();
    endtask

    task automatic test_simul_write();
        exp_t e;
        int   n;
        bit   ok;
        sb_q.push_back('{we: 1'b1, addr: 8'h92, data: 8'h22});
        eng_drive(1'b1, 8'h92, 8'h22);
        cpu_drive(1'b0, 1'b1, 8'h92, 8'h11);
        @(negedge clk);
        checks++; if (bus.eng_gnt !== 1'b1) begin failures++; $display("FAIL sim_gnt: got %b want 1", bus.eng_gnt); end
        checks++; if (bus.mem_wr_n !== 1'b0 || bus.mem_wdata !== 8'h11) begin failures++; $display("FAIL sim_core_write: got wr_n=%b data %h want 0/11", bus.mem_wr_n, bus.mem_wdata); end
        step();
        bus.eng_req = 1'b0;
        cpu_drive(1'b1, 1'b1, 8'h00, 8'h00);
        wait_done(6, n, ok);
        checks++; if (!ok || n != 1) begin failures++; $display("FAIL sim_latency: got ok=%b n=%0d want ok=1 n=1", ok, n); end
        checks++;
        if (sb_q.size() == 0) begin failures++; $display("FAIL sim_sb: got empty queue want entry"); end
        else begin
            e = sb_q.pop_front();
            if (sfr_mem[e.addr] !== e.data) begin failures++; $display("FAIL sim_mem: got %h want %h", sfr_mem[e.addr], e.data); end
        end
        step();
        cpu_drive(1'b1, 1'b0, 8'h92, 8'h00);
        @(negedge clk);
        checks++; if (bus.cpu_rdata !== 8'h22) begin failures++; $display("FAIL sim_final: got %h want 22", bus.cpu_rdata); end
        step();
        cpu_drive(1'b1, 1'b1, 8'h00, 8'h00);
    endtask

    task automatic test_back_to_back();
        exp_t e;
        int   gap;
        bit   got;
        int   n;
        bit   ok;
        sb_q.push_back('{we: 1'b1, addr: 8'hA0, data: 8'h01});
        sb_q.push_back('{we: 1'b1, addr: 8'hA1, data: 8'h02});
        eng_drive(1'b1, 8'hA0, 8'h01);
        @(negedge clk);
        checks++; if (bus.eng_gnt !== 1'b1) begin failures++; $display("FAIL b2b_gnt0: got %b want 1", bus.eng_gnt); end
        step();
        eng_drive(1'b1, 8'hA1, 8'h02);
        gap = 0;
        got = 1'b0;
        for (int k = 1; k <= 6 && !got; k++) begin
            @(negedge clk);
            if (bus.eng_done === 1'b1) begin
                checks++;
                if (sb_q.size() == 0) begin failures++; $display("FAIL b2b_sb0: got empty queue want entry"); end
                else begin
                    e = sb_q.pop_front();
                    if (sfr_mem[e.addr] !== e.data) begin failures++; $display("FAIL b2b_mem0: got %h want %h", sfr_mem[e.addr], e.data); end
                end
            end
            if (bus.eng_gnt === 1'b1) begin
                gap = k;
                got = 1'b1;
            end else begin
                step();
            end
        end
        checks++; if (gap != 3) begin failures++; $display("FAIL b2b_gap: got %0d want 3", gap); end
        step();
        bus.eng_req = 1'b0;
        wait_done(6, n, ok);
        checks++; if (!ok || n != 1) begin failures++; $display("FAIL b2b_latency1: got ok=%b n=%0d want ok=1 n=1", ok, n); end
        checks++;
        if (sb_q.size() == 0) begin failures++; $display("FAIL b2b_sb1: got empty queue want entry"); end
        else begin
            e = sb_q.pop_front();
            if (sfr_mem[e.addr] !== e.data) begin failures++; $display("FAIL b2b_mem1: got %h want %h", sfr_mem[e.addr], e.data); end
        end
        step();
    endtask

    task automatic test_starve();
        exp_t e;
        logic exp_flag;
        int   n;
        bit   ok;
        sb_q.push_back('{we: 1'b0, addr: 8'h93, data: 8'hC9});
        eng_drive(1'b0, 8'h93, 8'h00);
        @(negedge clk);
        checks++; if (bus.eng_gnt !== 1'b1) begin failures++; $display("FAIL stv_gnt: got %b want 1", bus.eng_gnt); end
        step();
        bus.eng_req = 1'b0;
        cpu_drive(1'b1, 1'b0, 8'h10, 8'h00);
        for (int i = 1; i <= 6; i++) begin
            @(negedge clk);
            exp_flag = STARVE_ON && ((i - 1) >= TB_STARVE_MAX);
            checks++; if (bus.eng_starve !== exp_flag) begin failures++; $display("FAIL stv_flag_c%0d: got %b want %b", i, bus.eng_starve, exp_flag); end
            step();
        end
        cpu_drive(1'b1, 1'b1, 8'h00, 8'h00);
        wait_done(6, n, ok);
        checks++; if (!ok || n != 1) begin failures++; $display("FAIL stv_latency: got ok=%b n=%0d want ok=1 n=1", ok, n); end
        checks++;
        if (sb_q.size() == 0) begin failures++; $display("FAIL stv_sb: got empty queue want entry"); end
        else begin
            e = sb_q.pop_front();
            if (bus.eng_rdata !== e.data) begin failures++; $display("FAIL stv_rdata: got %h want %h", bus.eng_rdata, e.data); end
        end
        step();
        @(negedge clk);
        checks++; if (bus.eng_starve !== STARVE_ON) begin failures++; $display("FAIL stv_sticky: got %b want %b", bus.eng_starve, STARVE_ON); end
        step();
    endtask

    task automatic test_reset_mid();
        exp_t        e;
        int unsigned wr_before;
        bit          seen_done;
        int          n;
        bit          ok;
        wr_before = wr_count;
        eng_drive(1'b1, 8'h94, 8'hEE);
        @(negedge clk);
        checks++; if (bus.eng_gnt !== 1'b1) begin failures++; $display("FAIL rmid_gnt: got %b want 1", bus.eng_gnt); end
        step();
        bus.eng_req = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        checks++; if (bus.mem_wr_n !== 1'b1) begin failures++; $display("FAIL rmid_no_issue: got wr_n=%b want 1", bus.mem_wr_n); end
        step();
        rst_n = 1'b1;
        seen_done = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (bus.eng_done === 1'b1) seen_done = 1'b1;
            step();
        end
        checks++; if (seen_done) begin failures++; $display("FAIL rmid_done: got eng_done want none"); end
        checks++; if (wr_count != wr_before) begin failures++; $display("FAIL rmid_writes: got %0d want %0d", wr_count, wr_before); end
        checks++; if (sfr_mem[8'h94] !== 8'hCE) begin failures++; $display("FAIL rmid_mem: got %h want ce", sfr_mem[8'h94]); end
        checks++; if (bus.eng_starve !== 1'b0 || bus.eng_rdata !== 8'h00) begin failures++; $display("FAIL rmid_clear: got starve=%b rdata=%h want 0/00", bus.eng_starve, bus.eng_rdata); end
        sb_q.push_back('{we: 1'b1, addr: 8'h95, data: 8'h55});
        eng_drive(1'b1, 8'h95, 8'h55);
        @(negedge clk);
        checks++; if (bus.eng_gnt !== 1'b1) begin failures++; $display("FAIL rmid_idle_gnt: got %b want 1", bus.eng_gnt); end
        step();
        bus.eng_req = 1'b0;
        wait_done(6, n, ok);
        checks++; if (!ok || n != 1) begin failures++; $display("FAIL rmid_latency: got ok=%b n=%0d want ok=1 n=1", ok, n); end
        checks++;
        if (sb_q.size() == 0) begin failures++; $display("FAIL rmid_sb: got empty queue want entry"); end
        else begin
            e = sb_q.pop_front();
            if (sfr_mem[e.addr] !== e.data) begin failures++; $display("FAIL rmid_mem2: got %h want %h", sfr_mem[e.addr], e.data); end
        end
        step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish want finish");
        $fatal(1);
    end

    initial begin
        bus.eng_req   = 1'b0;
        bus.eng_we    = 1'b0;
        bus.eng_addr  = 8'h00;
        bus.eng_wdata = 8'h00;
        cpu_drive(1'b1, 1'b1, 8'h00, 8'h00);
        test_reset();
        test_eng_write();
        test_core_priority();
        test_simul_write();
        test_back_to_back();
        test_starve();
        test_reset_mid();
        checks++; if (sb_q.size() != 0) begin failures++; $display("FAIL sb_drain: got %0d entries want 0", sb_q.size()); end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
